// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, load-size
// encodings and the MEM/WB control record.
package mips_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    load_size_e size;
    logic       load_unsigned;
    logic [4:0] dest;
    logic [1:0] offset;
  } wb_ctrl_t;

endpackage

// File: rtl/load_extract.sv
// Big-endian load extraction: selects a byte/half/word from the raw memory
// word and sign- or zero-extends it. Purely combinational.
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] value_o,
  output logic        align_err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_sel = '0;
    unique case (offset_i)
      2'd0: byte_sel = data_i[31:24];
      2'd1: byte_sel = data_i[23:16];
      2'd2: byte_sel = data_i[15:8];
      2'd3: byte_sel = data_i[7:0];
      default: byte_sel = '0;
    endcase
  end

  // offset[0] is ignored for halves; the misalignment is flagged separately
  assign half_sel  = offset_i[1] ? data_i[15:0] : data_i[31:16];
  assign byte_sign = ~unsigned_i & byte_sel[7];
  assign half_sign = ~unsigned_i & half_sel[15];

  always_comb begin
    value_o = data_i;
    unique case (load_size_e'(size_i))
      LS_BYTE: value_o = {{24{byte_sign}}, byte_sel};
      LS_HALF: value_o = {{16{half_sign}}, half_sel};
      LS_WORD: value_o = data_i;
      LS_RSVD: value_o = data_i;
      default: value_o = data_i;
    endcase
  end

  assign align_err_o = (load_size_e'(size_i) == LS_HALF) && offset_i[0];

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage: drives the register-file
// write port and the MEM/WB forwarding value, and counts retired instructions.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = mips_pkg::DATA_W,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ZERO_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Valid,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemtoReg,
  input  logic [1:0]        MEM_LoadSize,
  input  logic              MEM_LoadUnsigned,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic [DATA_W-1:0] MEM_ALUresult,
  input  logic [4:0]        MEM_RegDest,
  input  logic              Stall,
  input  logic              Flush,
  output logic              WB_Valid,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_RegDest,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic              WB_AlignErr,
  output logic [CNT_W-1:0]  RetireCount
);

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] load_val;
  logic              load_misalign;
  logic              align_err;
  logic              dest_ok;
  logic              retire;

  always_comb begin
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    if (Flush) begin
      ctrl_d  = '0;
      rdata_d = '0;
      alu_d   = '0;
    end else if (!Stall) begin
      ctrl_d.valid         = MEM_Valid;
      ctrl_d.regwrite      = MEM_RegWrite;
      ctrl_d.memtoreg      = MEM_MemtoReg;
      ctrl_d.size          = load_size_e'(MEM_LoadSize);
      ctrl_d.load_unsigned = MEM_LoadUnsigned;
      ctrl_d.dest          = MEM_RegDest;
      ctrl_d.offset        = MEM_ALUresult[1:0];
      rdata_d              = MEM_ReadData;
      alu_d                = MEM_ALUresult;
    end
  end

  // An instruction leaves WB when the register advances; a flush also evicts it
  assign retire = ctrl_q.valid & (~Stall | Flush);

  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
    end
  end

  load_extract u_load_extract (
    .data_i      (rdata_q),
    .offset_i    (ctrl_q.offset),
    .size_i      (ctrl_q.size),
    .unsigned_i  (ctrl_q.load_unsigned),
    .value_o     (load_val),
    .align_err_o (load_misalign)
  );

  assign align_err = load_misalign & ctrl_q.memtoreg & ctrl_q.valid;
  assign dest_ok   = (ZERO_GUARD == 0) || (ctrl_q.dest != REG_ZERO);

  assign WB_Valid     = ctrl_q.valid;
  assign WB_RegDest   = ctrl_q.dest;
  assign WB_WriteData = ctrl_q.memtoreg ? load_val : alu_q;
  assign WB_AlignErr  = align_err;
  assign WB_RegWrite  = ctrl_q.regwrite & ctrl_q.valid & ~align_err & dest_ok;
  assign RetireCount  = cnt_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: a transaction-level model checked
// every cycle, plus hand-computed literal expectations.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_Valid = 1'b0, MEM_RegWrite = 1'b0, MEM_MemtoReg = 1'b0;
  logic [1:0]  MEM_LoadSize = 2'b00;
  logic        MEM_LoadUnsigned = 1'b0;
  logic [31:0] MEM_ReadData = '0, MEM_ALUresult = '0;
  logic [4:0]  MEM_RegDest = '0;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic        WB_Valid, WB_RegWrite, WB_AlignErr;
  logic [4:0]  WB_RegDest;
  logic [31:0] WB_WriteData;
  logic [31:0] RetireCount;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(32), .CNT_W(32), .ZERO_GUARD(1)) dut (
    .clk(clk), .rst(rst),
    .MEM_Valid(MEM_Valid), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_LoadSize(MEM_LoadSize), .MEM_LoadUnsigned(MEM_LoadUnsigned),
    .MEM_ReadData(MEM_ReadData), .MEM_ALUresult(MEM_ALUresult), .MEM_RegDest(MEM_RegDest),
    .Stall(Stall), .Flush(Flush),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .WB_WriteData(WB_WriteData), .WB_AlignErr(WB_AlignErr), .RetireCount(RetireCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the instruction currently sitting in WB plus a retire tally
  typedef struct {
    logic        v, rw, m2r;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rd, alu;
    logic [4:0]  dst;
  } rec_t;

  rec_t        m   = '{default: '0};
  logic [31:0] cnt = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m   <= '{default: '0};
      cnt <= '0;
    end else begin
      if (m.v && (!Stall || Flush)) cnt <= cnt + 32'd1;
      if (Flush) m <= '{default: '0};
      else if (!Stall)
        m <= '{MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_LoadSize, MEM_LoadUnsigned,
               MEM_ReadData, MEM_ALUresult, MEM_RegDest};
    end
  end

  function automatic logic [31:0] model_data(input rec_t r);
    logic [31:0] f, mask;
    int          w, sh;
    if (!r.m2r) return r.alu;
    if (r.sz == 2'b10) begin
      w  = 8;
      sh = 8 * (3 - int'(r.alu[1:0]));
    end else if (r.sz == 2'b01) begin
      w  = 16;
      sh = r.alu[1] ? 0 : 16;
    end else begin
      return r.rd;
    end
    mask = (32'd1 << w) - 32'd1;
    f = (r.rd >> sh) & mask;
    if (!r.uns && f[w-1]) f = f | ~mask;
    return f;
  endfunction

  function automatic logic model_align(input rec_t r);
    return r.v && r.m2r && (r.sz == 2'b01) && r.alu[0];
  endfunction

  function automatic logic model_rw(input rec_t r);
    return r.v && r.rw && !model_align(r) && (r.dst != 5'd0);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", {31'd0, WB_Valid},    {31'd0, m.v});
      chk("m_rw",    {31'd0, WB_RegWrite}, {31'd0, model_rw(m)});
      chk("m_dest",  {27'd0, WB_RegDest},  {27'd0, m.dst});
      chk("m_data",  WB_WriteData,         model_data(m));
      chk("m_align", {31'd0, WB_AlignErr}, {31'd0, model_align(m)});
      chk("m_cnt",   RetireCount,          cnt);
    end
  end

  task automatic issue(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                       input logic uns, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] dst);
    MEM_Valid = v; MEM_RegWrite = rw; MEM_MemtoReg = m2r; MEM_LoadSize = sz;
    MEM_LoadUnsigned = uns; MEM_ReadData = rd; MEM_ALUresult = alu; MEM_RegDest = dst;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  localparam logic [31:0] LD = 32'h80FF_7F01;

  initial begin
    #1 rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, WB_Valid}, 32'd0);
    chk("rst_rw",    {31'd0, WB_RegWrite}, 32'd0);
    chk("rst_data",  WB_WriteData, 32'd0);
    chk("rst_cnt",   RetireCount, 32'd0);
    rst = 1'b1;

    issue(1, 1, 0, 2'b00, 0, 32'h0, 32'h0000_1234, 5'd8);
    chk("alu_rw",   {31'd0, WB_RegWrite}, 32'd1);
    chk("alu_dest", {27'd0, WB_RegDest}, 32'd8);
    chk("alu_data", WB_WriteData, 32'h0000_1234);
    chk("alu_cnt0", RetireCount, 32'd0);

    issue(1, 1, 1, 2'b10, 0, LD, 32'h0000_0100, 5'd9);
    chk("alu_cnt1", RetireCount, 32'd1);
    chk("lb_s_o0",  WB_WriteData, 32'hFFFF_FF80);
    issue(1, 1, 1, 2'b10, 1, LD, 32'h0000_0101, 5'd9);
    chk("lb_u_o1",  WB_WriteData, 32'h0000_00FF);
    issue(1, 1, 1, 2'b10, 0, LD, 32'h0000_0102, 5'd9);
    chk("lb_s_o2",  WB_WriteData, 32'h0000_007F);
    issue(1, 1, 1, 2'b10, 0, LD, 32'h0000_0103, 5'd9);
    chk("lb_s_o3",  WB_WriteData, 32'h0000_0001);
    issue(1, 1, 1, 2'b01, 0, LD, 32'h0000_0102, 5'd9);
    chk("lh_s_o2",  WB_WriteData, 32'h0000_7F01);
    issue(1, 1, 1, 2'b01, 1, LD, 32'h0000_0100, 5'd9);
    chk("lh_u_o0",  WB_WriteData, 32'h0000_80FF);
    issue(1, 1, 1, 2'b01, 0, LD, 32'h0000_0101, 5'd9);
    chk("lh_mis_err",  {31'd0, WB_AlignErr}, 32'd1);
    chk("lh_mis_rw",   {31'd0, WB_RegWrite}, 32'd0);
    chk("lh_mis_data", WB_WriteData, 32'hFFFF_80FF);
    issue(1, 1, 1, 2'b00, 0, LD, 32'h0000_0103, 5'd9);
    chk("lw",       WB_WriteData, LD);
    issue(1, 1, 1, 2'b11, 0, LD, 32'h0000_0102, 5'd9);
    chk("lrsvd",    WB_WriteData, LD);
    issue(1, 1, 0, 2'b00, 0, 32'h0, 32'hDEAD_BEEF, 5'd0);
    chk("zg_rw",    {31'd0, WB_RegWrite}, 32'd0);
    chk("zg_data",  WB_WriteData, 32'hDEAD_BEEF);
    chk("zg_cnt",   RetireCount, 32'd10);

    issue(1, 1, 0, 2'b00, 0, 32'h0, 32'hAAAA_0001, 5'd9);
    chk("pre_stall_cnt", RetireCount, 32'd11);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1, 1, 0, 2'b00, 0, 32'h0, 32'h0000_5555, 5'd10);
      chk("stall_data", WB_WriteData, 32'hAAAA_0001);
      chk("stall_dest", {27'd0, WB_RegDest}, 32'd9);
      chk("stall_cnt",  RetireCount, 32'd11);
    end
    Stall = 1'b0;
    issue(1, 1, 0, 2'b00, 0, 32'h0, 32'h0000_5555, 5'd10);
    chk("rel_data", WB_WriteData, 32'h0000_5555);
    chk("rel_dest", {27'd0, WB_RegDest}, 32'd10);
    chk("rel_cnt",  RetireCount, 32'd12);

    Flush = 1'b1; Stall = 1'b1;
    issue(1, 1, 0, 2'b00, 0, 32'h0, 32'h0000_7777, 5'd11);
    chk("fs_valid", {31'd0, WB_Valid}, 32'd0);
    chk("fs_rw",    {31'd0, WB_RegWrite}, 32'd0);
    chk("fs_cnt",   RetireCount, 32'd13);
    Flush = 1'b0; Stall = 1'b0;
    issue(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    chk("bub_cnt",  RetireCount, 32'd13);

    #2 rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 1; i <= 6; i++)
      issue(1, 1, 0, 2'b00, 0, 32'h0, 32'h100 + 32'(i), 5'd3);
    chk("pre_ar_cnt", RetireCount, 32'd5);
    chk("pre_ar_rw",  {31'd0, WB_RegWrite}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_cnt",   RetireCount, 32'd0);
    chk("ar_rw",    {31'd0, WB_RegWrite}, 32'd0);
    chk("ar_valid", {31'd0, WB_Valid}, 32'd0);
    chk("ar_data",  WB_WriteData, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_ar_rw",   {31'd0, WB_RegWrite}, 32'd1);
    chk("post_ar_data", WB_WriteData, 32'h0000_0106);
    chk("post_ar_cnt",  RetireCount, 32'd0);
    issue(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    chk("post_ar_cnt1", RetireCount, 32'd1);

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
